conv_tap_feeder: RTL
====================

# conv_tap_feeder

Front end of the 3-tap transposed convolution stage. It accepts an unsigned pixel stream through a valid/ready handshake and multiplies each pixel by three signed kernel weights. It drives the 48-bit packed product word, `enable` and `num_block_change` into the tap accumulator. It also generates row framing and a valid/last strobe aligned to the accumulator's registered 16-bit output.

## Interface
- `PIX_W`, 8: input pixel width (unsigned)
- `W_W`, 8: weight width (signed two's complement)
- `ROW_LEN`, 28: pixels per row; minimum 3
- `NUM_ROWS`, 28: rows per frame; minimum 1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `w_load`  in  1  weight write strobe; honoured only in IDLE
- `w_sel`  in  2  weight index 0..2; value 3 is ignored
- `w_data`  in  W_W  weight value
- `start`  in  1  begin a frame; honoured only in IDLE
- `in_valid`  in  1  pixel available
- `in_ready`  out  1  feeder accepts a pixel
- `in_pixel`  in  PIX_W  pixel value
- `pix`  out  48  {x·w2, x·w1, x·w0}; bits [15:0] hold x·w0, bits [47:32] hold x·w2
- `enable`  out  1  accumulator shift/add strobe
- `num_block_change`  out  1  accumulator clear pulse at row start
- `out_valid`  out  1  accumulator output holds a complete 3-tap sum
- `out_last`  out  1  final valid output of the frame
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle end-of-frame pulse

## Operation
- Weights w0..w2 are held in registers that reset to 0 and persist across frames.
- States: IDLE, CLEAR, STREAM, DRAIN1, DRAIN2.
- IDLE:
  - `start` moves the FSM to CLEAR and clears the row and column counters.
  - `w_load` writes `w[w_sel]`.
- CLEAR lasts one cycle:
  - registers `num_block_change`=1, `enable`=0 and `in_ready`=0.
  - then goes to STREAM.
- STREAM:
  - `in_ready`=1.
  - On accept (`in_valid & in_ready`), the feeder registers `pix` from the three products, registers `enable`=1 and increments the column counter.
  - In a non-accept cycle, `enable` is registered 0 and `pix` holds its value.
- Row end is the accept at column ROW_LEN-1:
  - column resets to 0.
  - If row < NUM_ROWS-1, row increments and the FSM goes to CLEAR.
  - Otherwise the FSM goes to DRAIN1.
- DRAIN1 then DRAIN2, then IDLE. `done` is 1 during DRAIN2.
- Products:
  - The pixel is zero-extended to a signed value and multiplied by the signed weight.
  - The result is exact in 16-bit signed: range -32640..32385. No saturation is applied.
- Downstream sum = x[c-2]·w0 + x[c-1]·w1 + x[c]·w2.
  - The accumulator wraps modulo 2^16. The feeder does not guard against this overflow.
- `out_valid`:
  - Asserted for the accept of column c ≥ 2 only.
  - Each row yields ROW_LEN-2 valid outputs.
  - `out_last` = `out_valid` for the last column of the last row.
- There is no downstream backpressure: the accumulator consumes every `enable`.
- `start`, `w_load` and `w_sel`=3 outside their allowed states are silently ignored.

## Timing
- Reset (`rst`=0) immediately clears all of the following, independent of `clk`:
  - outputs `pix`=0, `enable`=0, `num_block_change`=0, `in_ready`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
  - all weights, counters and pipeline registers.
  - FSM state, which returns to IDLE.
- Reset mid-frame abandons the frame. After release the feeder sits in IDLE with weights at 0.
- `start` sampled at edge k:
  - CLEAR during cycle k+1, with `num_block_change`=1 and `busy`=1.
  - STREAM from cycle k+2.
- Pixel accepted at edge k:
  - `pix`/`enable` are valid in cycle k+1, and the accumulator captures at edge k+1.
  - `out_valid` is 1 in cycle k+2 if column ≥ 2.
- Each row boundary inserts exactly one CLEAR cycle, during which `in_ready`=0.
- The `num_block_change` cycle always has `enable`=0.
- Last frame pixel accepted at edge k:
  - DRAIN1 in cycle k+1.
  - DRAIN2 in cycle k+2, with `out_valid`=`out_last`=`done`=1.
  - IDLE with `busy`=0 in cycle k+3.
- `busy` is 1 from CLEAR through DRAIN2 inclusive.
- Throughput: one pixel per cycle in STREAM. Frame length is ROW_LEN·NUM_ROWS + NUM_ROWS + 2 cycles at full rate.

## Test plan
- Basic window:
  - Stimulus: ROW_LEN=4, NUM_ROWS=1, weights 1,2,3, pixels 1,2,3,4 at full rate.
  - `pix` per accept: {3,2,1}, {6,4,2}, {9,6,3}, {12,8,4}.
  - Downstream `out_valid` twice, with sums 14 then 20. `out_last` and `done` occur with 20.
- Signed extremes:
  - All weights -128, pixel 255 → every 16-bit lane of `pix` = 0x8080.
  - All weights 127, pixel 255 → every lane = 0x7E81.
- Bubbles: toggle `in_valid` 1,0,0,1,1,0,1 over the basic test.
  - `enable` is high only one cycle after each accept.
  - Sums are identical to the basic window test.
- Row framing: ROW_LEN=4, NUM_ROWS=2.
  - Exactly one `num_block_change` cycle before each row, with `in_ready`=0 and `enable`=0.
  - 2 `out_valid` pulses per row.
  - `out_last` only on the 4th `out_valid` pulse.
- Async reset mid-row: drive `rst` low between clock edges during STREAM.
  - All outputs go to 0 before the next edge.
  - After release: IDLE, with weights re-reading as 0 (first frame `pix`=0).
- Ignored controls:
  - `w_load` of 5 to w0 and `start` while `busy` → no effect on products or frame count.
  - `w_sel`=3 in IDLE → no weight changes.

Source files
------------

// File: rtl/conv_tap_feeder_if.sv
// Pixel stream handshake between an upstream source and the convolution feeder.
// The master drives pixels; the slave (feeder) answers with ready.
interface conv_tap_feeder_if #(
    parameter int PIX_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;

    modport master (
        output in_valid,
        output in_pixel,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        output in_ready
    );
endinterface

// File: rtl/conv_tap_feeder.sv
// Front end of the 3-tap transposed convolution: multiplies each accepted pixel by
// three signed weights and frames rows/frames for the downstream tap accumulator.
module conv_tap_feeder #(
    parameter int PIX_W    = 8,
    parameter int W_W      = 8,
    parameter int ROW_LEN  = 28,
    parameter int NUM_ROWS = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_load,
    input  logic [1:0]           w_sel,
    input  logic [W_W-1:0]       w_data,
    input  logic                 start,
    conv_tap_feeder_if.slave     px,
    output logic [47:0]          pix,
    output logic                 enable,
    output logic                 num_block_change,
    output logic                 out_valid,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int LANE_W = 16;
    localparam int COL_W  = $clog2(ROW_LEN);
    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN1 = 3'd3,
        S_DRAIN2 = 3'd4
    } state_t;

    // Unsigned pixel times signed weight; the exact product always fits 16 bits.
    function automatic logic [LANE_W-1:0] mul_lane(input logic [PIX_W-1:0] x,
                                                   input logic signed [W_W-1:0] w);
        return LANE_W'($signed({1'b0, x}) * w);
    endfunction

    state_t                 state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic signed [W_W-1:0]  w0_q, w1_q, w2_q;
    logic [47:0]            pix_q;
    logic                   enable_q, nbc_q, in_ready_q, busy_q, done_q;
    logic                   ov_pend_q, ol_pend_q, out_valid_q, out_last_q;
    logic                   accept_s, row_end_s, last_row_s;

    // Next-state and counter update logic.
    always_comb begin
        accept_s   = (state_q == S_STREAM) && px.in_valid && in_ready_q;
        row_end_s  = accept_s && (col_q == COL_LAST);
        last_row_s = (row_q == ROW_LAST);
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR:  state_d = S_STREAM;
            S_STREAM: begin
                if (row_end_s) begin
                    col_d = '0;
                    if (last_row_s) begin
                        state_d = S_DRAIN1;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_CLEAR;
                    end
                end else if (accept_s) begin
                    col_d = col_q + COL_W'(1);
                end else begin
                    col_d = col_q;
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, weights and all outputs; controls are Moore on the next state so they
    // line up with the cycle the FSM actually occupies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            pix_q       <= 48'd0;
            enable_q    <= 1'b0;
            nbc_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ov_pend_q   <= 1'b0;
            ol_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            in_ready_q <= (state_d == S_STREAM);
            nbc_q      <= (state_d == S_CLEAR);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DRAIN2);
            enable_q   <= accept_s;
            if (accept_s) begin
                pix_q <= {mul_lane(px.in_pixel, w2_q),
                          mul_lane(px.in_pixel, w1_q),
                          mul_lane(px.in_pixel, w0_q)};
            end
            // Accumulator output lags the enable by one edge, so flag it one stage later.
            ov_pend_q   <= accept_s && (col_q >= COL_W'(2));
            ol_pend_q   <= row_end_s && last_row_s;
            out_valid_q <= ov_pend_q;
            out_last_q  <= ol_pend_q;
            if ((state_q == S_IDLE) && w_load) begin
                case (w_sel)
                    2'd0:    w0_q <= w_data;
                    2'd1:    w1_q <= w_data;
                    2'd2:    w2_q <= w_data;
                    default: ;
                endcase
            end
        end
    end

    assign px.in_ready       = in_ready_q;
    assign pix               = pix_q;
    assign enable            = enable_q;
    assign num_block_change  = nbc_q;
    assign out_valid         = out_valid_q;
    assign out_last          = out_last_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule
